cmp_result_tally: RTL and testbench

//   Downstream consumer of the 8-bit comparator flags {gt,eq,le}. Tallies outcomes per frame:
//   gt/eq/lt counts, sample count and longest run of consecutive gt.

---
 rtl/cmp_tally_pkg.sv | 18 +
 rtl/cmp_run_tracker.sv | 42 ++++
 rtl/cmp_result_tally.sv | 188 ++++++++++++++++++
 tb/tb_cmp_result_tally.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_tally_pkg.sv
// Shared types and flag encodings for the comparator-result tally block.
package cmp_tally_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam logic [2:0] FLAG_GT = 3'b100;
    localparam logic [2:0] FLAG_EQ = 3'b010;
    localparam logic [2:0] FLAG_LT = 3'b001;

    // A flag vector is legal only when it is exactly one of the one-hot codes.
    function automatic logic flag_is_legal(input logic [2:0] flags);
        return (flags == FLAG_GT) || (flags == FLAG_EQ) || (flags == FLAG_LT);
    endfunction

endpackage

// File: rtl/cmp_run_tracker.sv
// Tracks the current and longest run of consecutive gt samples within a frame.
// max_run presents the look-ahead value that includes this cycle's step.
module cmp_run_tracker #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    input  logic             is_gt,
    output logic [CNT_W-1:0] max_run
);

    logic [CNT_W-1:0] r_cur_run;
    logic [CNT_W-1:0] r_max_run;
    logic [CNT_W-1:0] w_cur_nxt;
    logic [CNT_W-1:0] w_max_nxt;

    always_comb begin
        w_cur_nxt = r_cur_run;
        w_max_nxt = r_max_run;
        if (step) begin
            w_cur_nxt = is_gt ? (r_cur_run + CNT_W'(1)) : '0;
            if (w_cur_nxt > r_max_run) begin
                w_max_nxt = w_cur_nxt;
            end
        end
    end

    assign max_run = w_max_nxt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cur_run <= '0;
            r_max_run <= '0;
        end else begin
            r_cur_run <= w_cur_nxt;
            r_max_run <= w_max_nxt;
        end
    end

endmodule

// File: rtl/cmp_result_tally.sv
// Per-frame tally of comparator flags with a valid/ready summary output.
// Optional CMP_TALLY_ERRCHK_EN adds illegal-vector count and sticky error ports.
module cmp_result_tally
    import cmp_tally_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             gt,
    input  logic             eq,
    input  logic             le,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] smp_cnt,
    output logic [CNT_W-1:0] max_gt_run
`ifdef CMP_TALLY_ERRCHK_EN
    ,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky
`endif
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             w_accept;
    logic             w_close;
    logic             w_handoff;
    logic [2:0]       w_flags;

    logic [CNT_W-1:0] r_gt;
    logic [CNT_W-1:0] r_eq;
    logic [CNT_W-1:0] r_lt;
    logic [CNT_W-1:0] r_smp;
    logic [CNT_W-1:0] w_gt_nxt;
    logic [CNT_W-1:0] w_eq_nxt;
    logic [CNT_W-1:0] w_lt_nxt;
    logic [CNT_W-1:0] w_smp_nxt;
    logic [CNT_W-1:0] w_max_run;

    logic [CNT_W-1:0] r_sum_gt;
    logic [CNT_W-1:0] r_sum_eq;
    logic [CNT_W-1:0] r_sum_lt;
    logic [CNT_W-1:0] r_sum_smp;
    logic [CNT_W-1:0] r_sum_run;

    assign w_flags = {gt, eq, le};

    // Next state and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_close     = 1'b0;
        w_handoff   = 1'b0;
        unique case (r_state)
            ACCUM: begin
                w_accept = in_valid && r_in_ready;
                w_close  = (w_accept && (r_smp == CNT_W'(FRAME_LEN - 1)))
                         || (flush && (w_accept || (r_smp != '0)));
                if (w_close) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_handoff   = 1'b1;
                    w_state_nxt = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_gt_nxt  = r_gt  + CNT_W'(w_accept && (w_flags == FLAG_GT));
    assign w_eq_nxt  = r_eq  + CNT_W'(w_accept && (w_flags == FLAG_EQ));
    assign w_lt_nxt  = r_lt  + CNT_W'(w_accept && (w_flags == FLAG_LT));
    assign w_smp_nxt = r_smp + CNT_W'(w_accept);

    cmp_run_tracker #(
        .CNT_W (CNT_W)
    ) u_run_tracker (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_handoff),
        .step    (w_accept),
        .is_gt   (w_flags == FLAG_GT),
        .max_run (w_max_run)
    );

    // Handshake flags mirror the upcoming state; summaries capture post-update totals on close.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_gt        <= '0;
            r_eq        <= '0;
            r_lt        <= '0;
            r_smp       <= '0;
            r_sum_gt    <= '0;
            r_sum_eq    <= '0;
            r_sum_lt    <= '0;
            r_sum_smp   <= '0;
            r_sum_run   <= '0;
        end else begin
            r_in_ready  <= (w_state_nxt == ACCUM);
            r_out_valid <= (w_state_nxt == HOLD);
            if (w_handoff) begin
                r_gt  <= '0;
                r_eq  <= '0;
                r_lt  <= '0;
                r_smp <= '0;
            end else if (w_accept) begin
                r_gt  <= w_gt_nxt;
                r_eq  <= w_eq_nxt;
                r_lt  <= w_lt_nxt;
                r_smp <= w_smp_nxt;
            end
            if (w_close) begin
                r_sum_gt  <= w_gt_nxt;
                r_sum_eq  <= w_eq_nxt;
                r_sum_lt  <= w_lt_nxt;
                r_sum_smp <= w_smp_nxt;
                r_sum_run <= w_max_run;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign gt_cnt     = r_sum_gt;
    assign eq_cnt     = r_sum_eq;
    assign lt_cnt     = r_sum_lt;
    assign smp_cnt    = r_sum_smp;
    assign max_gt_run = r_sum_run;

`ifdef CMP_TALLY_ERRCHK_EN
    logic             w_illegal;
    logic [CNT_W-1:0] r_err;
    logic [CNT_W-1:0] w_err_nxt;
    logic [CNT_W-1:0] r_sum_err;
    logic             r_err_sticky;

    assign w_illegal = w_accept && !flag_is_legal(w_flags);
    assign w_err_nxt = r_err + CNT_W'(w_illegal);

    // Illegal-vector count follows the frame; the sticky flag survives until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err        <= '0;
            r_sum_err    <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            if (w_handoff) begin
                r_err <= '0;
            end else if (w_accept) begin
                r_err <= w_err_nxt;
            end
            if (w_close) begin
                r_sum_err <= w_err_nxt;
            end
            if (w_illegal) begin
                r_err_sticky <= 1'b1;
            end
        end
    end

    assign err_cnt    = r_sum_err;
    assign err_sticky = r_err_sticky;
`endif

endmodule

// File: tb/tb_cmp_result_tally.sv
// Randomized and directed bench for cmp_result_tally against a frame-level reference model.
module tb_cmp_result_tally;

    localparam int unsigned FRAME_LEN = 16;
    localparam int unsigned CNT_W     = 8;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_ready;
    logic gt;
    logic eq;
    logic le;
    logic flush;
    logic out_valid;
    logic out_ready;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [CNT_W-1:0] smp_cnt;
    logic [CNT_W-1:0] max_gt_run;
`ifdef CMP_TALLY_ERRCHK_EN
    logic [CNT_W-1:0] err_cnt;
    logic             err_sticky;
`endif

    always #5 clk = ~clk;

    cmp_result_tally #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .gt         (gt),
        .eq         (eq),
        .le         (le),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .gt_cnt     (gt_cnt),
        .eq_cnt     (eq_cnt),
        .lt_cnt     (lt_cnt),
        .smp_cnt    (smp_cnt),
        .max_gt_run (max_gt_run)
`ifdef CMP_TALLY_ERRCHK_EN
        ,
        .err_cnt    (err_cnt),
        .err_sticky (err_sticky)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the accepted samples of the open frame plus the pending summary.
    bit         m_rdy = 1'b0;
    bit         m_valid = 1'b0;
    logic [2:0] m_q[$];
    int         e_gt, e_eq, e_lt, e_smp, e_run, e_err;
    bit         e_sticky = 1'b0;

    function automatic bit legal(input logic [2:0] v);
        return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
    endfunction

    function automatic void summarize();
        int run = 0;
        e_gt = 0; e_eq = 0; e_lt = 0; e_smp = 0; e_run = 0; e_err = 0;
        foreach (m_q[i]) begin
            e_smp++;
            case (m_q[i])
                3'b100:  begin e_gt++; run++; end
                3'b010:  begin e_eq++; run = 0; end
                3'b001:  begin e_lt++; run = 0; end
                default: begin e_err++; run = 0; end
            endcase
            if (run > e_run) e_run = run;
        end
    endfunction

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            m_q.delete();
            m_rdy = 1'b0;
            m_valid = 1'b0;
            e_sticky = 1'b0;
        end else if (!m_valid) begin
            acc = in_valid && m_rdy;
            if (acc) begin
                m_q.push_back({gt, eq, le});
                if (!legal({gt, eq, le})) e_sticky = 1'b1;
            end
            if ((acc && m_q.size() == FRAME_LEN) || (flush && m_q.size() > 0)) begin
                summarize();
                m_valid = 1'b1;
                m_rdy = 1'b0;
            end else begin
                m_rdy = 1'b1;
            end
        end else if (out_ready) begin
            m_q.delete();
            m_valid = 1'b0;
            m_rdy = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(m_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("gt_cnt", 32'(gt_cnt), e_gt);
            chk("eq_cnt", 32'(eq_cnt), e_eq);
            chk("lt_cnt", 32'(lt_cnt), e_lt);
            chk("smp_cnt", 32'(smp_cnt), e_smp);
            chk("max_gt_run", 32'(max_gt_run), e_run);
`ifdef CMP_TALLY_ERRCHK_EN
            chk("err_cnt", 32'(err_cnt), e_err);
`endif
        end
`ifdef CMP_TALLY_ERRCHK_EN
        chk("err_sticky", 32'(err_sticky), 32'(e_sticky));
`endif
    end

    task automatic idle(input logic fl, input logic ordy);
        @(negedge clk);
        in_valid = 1'b0;
        {gt, eq, le} = 3'b000;
        flush = fl;
        out_ready = ordy;
    endtask

    // Holds a sample on the input until the model says it is taken.
    task automatic send(input logic [2:0] f, input logic fl, input logic ordy);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 40) begin
            @(negedge clk);
            in_valid = 1'b1;
            {gt, eq, le} = f;
            flush = fl;
            out_ready = ordy;
            acc = m_rdy;
            n++;
        end
        if (!acc) chk("send_timeout", 32'(acc), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_gt", 32'(gt_cnt), 0);
        chk("rst_eq", 32'(eq_cnt), 0);
        chk("rst_lt", 32'(lt_cnt), 0);
        chk("rst_smp", 32'(smp_cnt), 0);
        chk("rst_run", 32'(max_gt_run), 0);
`ifdef CMP_TALLY_ERRCHK_EN
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_err_sticky", 32'(err_sticky), 0);
`endif
        rst = 1'b0;
    endtask

    function automatic logic [2:0] rnd_legal();
        logic [2:0] tbl [3] = '{3'b100, 3'b010, 3'b001};
        return tbl[$urandom_range(0, 2)];
    endfunction

    initial begin
        logic [2:0] pat [5] = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b001};
        logic [2:0] t2  [5] = '{3'b100, 3'b100, 3'b001, 3'b100, 3'b100};
        logic [2:0] rnd_tbl [6] = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b011, 3'b110};
        rst = 1'b1;
        in_valid = 1'b0;
        {gt, eq, le} = 3'b000;
        flush = 1'b0;
        out_ready = 1'b1;
        do_reset();

        // Full frame of a repeating pattern.
        for (int i = 0; i < 16; i++) send(pat[i % 5], 1'b0, 1'b1);
        idle(1'b0, 1'b1);
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_gt", 32'(gt_cnt), 10);
        chk("t1_eq", 32'(eq_cnt), 3);
        chk("t1_lt", 32'(lt_cnt), 3);
        chk("t1_smp", 32'(smp_cnt), 16);
        chk("t1_run", 32'(max_gt_run), 3);

        // Short frame closed by flush, then a flush on an empty frame.
        for (int i = 0; i < 5; i++) send(t2[i], 1'b0, 1'b1);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        chk("t2_valid", 32'(out_valid), 1);
        chk("t2_smp", 32'(smp_cnt), 5);
        chk("t2_gt", 32'(gt_cnt), 4);
        chk("t2_lt", 32'(lt_cnt), 1);
        chk("t2_run", 32'(max_gt_run), 2);
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b1);
        chk("t2_empty_flush", 32'(out_valid), 0);

        // Back-pressure while the summary is held.
        for (int i = 0; i < 16; i++) send(rnd_legal(), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            {gt, eq, le} = 3'b100;
            out_ready = 1'b0;
            chk("t3_hold_rdy", 32'(in_ready), 0);
            chk("t3_hold_valid", 32'(out_valid), 1);
        end
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);
        chk("t3_accum_rdy", 32'(in_ready), 1);
        for (int i = 0; i < 3; i++) send(3'b100, 1'b0, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b1);
        chk("t3_new_smp", 32'(smp_cnt), 3);

        // Flush coincident with the seventh accept.
        for (int i = 0; i < 6; i++) send(rnd_legal(), 1'b0, 1'b1);
        send(3'b010, 1'b1, 1'b1);
        idle(1'b0, 1'b1);
        chk("t4_smp", 32'(smp_cnt), 7);

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 9; i++) send(3'b100, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 16; i++) send(3'b001, 1'b0, 1'b1);
        idle(1'b0, 1'b1);
        chk("t5_smp", 32'(smp_cnt), 16);
        chk("t5_lt", 32'(lt_cnt), 16);
        chk("t5_gt", 32'(gt_cnt), 0);

        // Illegal vectors are still counted as samples.
        for (int i = 0; i < 16; i++)
            send((i == 3) ? 3'b000 : (i == 9) ? 3'b110 : rnd_legal(), 1'b0, 1'b1);
        idle(1'b0, 1'b1);
        chk("t6_smp", 32'(smp_cnt), 16);
`ifdef CMP_TALLY_ERRCHK_EN
        chk("t6_err_cnt", 32'(err_cnt), 2);
        chk("t6_sticky", 32'(err_sticky), 1);
        for (int i = 0; i < 16; i++) send(rnd_legal(), 1'b0, 1'b1);
        idle(1'b0, 1'b1);
        chk("t6_err_cnt2", 32'(err_cnt), 0);
        chk("t6_sticky2", 32'(err_sticky), 1);
        do_reset();
`endif

        // Random traffic with back-pressure, flushes and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            {gt, eq, le} = ($urandom_range(0, 9) < 8) ? rnd_legal() : rnd_tbl[$urandom_range(3, 5)];
            flush = ($urandom_range(0, 11) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
